eth_rx_mac_pipe: RTL and testbench
==================================

# eth_rx_mac_pipe

Parametrised next-generation Ethernet receive MAC between the RGMII PHY interface and the RX asynchronous FIFO. It detects preamble/SFD with a configurable minimum preamble length and streams frame bytes out on AXI-Stream through a 5-byte delay line so the FCS is stripped. Each frame is checked for FCS residue, PHY error, runt/oversize length and FIFO overflow, and errors are reported on `tuser` with `tlast`. Optional saturating statistics counters can be compiled in.

## Interface
- PREAMBLE_MIN, 7: minimum consecutive 0x55 bytes (with dv) before SFD; legal 1..7.
- MIN_FRAME_LEN, 64: minimum bytes from destination address through FCS inclusive.
- MAX_FRAME_LEN, 1518: maximum bytes, same counting; legal ≤ 16383.
- clk  in  1  rx clock from the PHY interface.
- reset_n  in  1  synchronous, active-low reset.
- rgmii_mac_rx_data  in  8  received byte.
- rgmii_mac_rx_dv  in  1  data valid.
- rgmii_mac_rx_er  in  1  PHY error.
- rgmii_mac_rx_rdy  in  1  byte strobe; all rx inputs sampled only when high ("beat").
- m_rx_axis_tdata  out  8  frame byte (FCS excluded).
- m_rx_axis_tvalid  out  1  one-cycle pulse per output byte.
- m_rx_axis_tlast  out  1  last byte of frame.
- m_rx_axis_tuser  out  1  frame bad; meaningful only with tlast.
- s_rx_axis_trdy  in  1  FIFO can accept; no stall is applied.
- stats_clear  in  1  synchronous clear of all counters.
- stat_good, stat_fcs_err, stat_len_err, stat_ovf_err  out  32 each  counters.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, DROP. All transitions happen only on beats.
- IDLE: dv=1 and byte 0x55 → PREAMBLE, pre_cnt=1.
- PREAMBLE: 0x55 with dv → pre_cnt+1 (saturates at 7). 0xD5 with dv, pre_cnt ≥ PREAMBLE_MIN and trdy=1 → PAYLOAD; clear the delay line, len=0, CRC=0xFFFFFFFF, error flags=0. Any other byte, dv=0 or trdy=0 → IDLE.
- PAYLOAD, beat with dv=1: push the byte into delay line D0..D4 and update the CRC (reflected CRC-32, polynomial 0x04C11DB7) with it. len+1. rx_er=1 sets err_phy. When D4 holds valid data before the shift, output D4 with tlast=0.
- PAYLOAD, beat with dv=0: frame end. Output D4 with tlast=1. D0..D3 hold the FCS and are discarded. Then → IDLE.
- Frame-end tuser=1 if any of: CRC register ≠ 0xDEBB20E3, err_phy, or len < MIN_FRAME_LEN.
- Frame end with fewer than 5 bytes received: no byte exists to carry tlast. Emit tdata=0x00, tlast=1, tuser=1, and count the frame as a length error.
- Oversize: a beat that would make len = MAX_FRAME_LEN+1 emits that beat's output with tlast=1 and tuser=1, then → DROP.
- Overflow: trdy=0 on any PAYLOAD beat forces that beat's output to tlast=1 and tuser=1, with tvalid=1 even if no byte was due, then → DROP.
- DROP: ignore input until a beat with dv=0, then → IDLE. No output in DROP.
- Each frame produces exactly one tlast.
- Error priority for counters: overflow > length > FCS/phy. Each frame increments exactly one counter. stat_fcs_err includes err_phy.

## Timing
- Reset: state IDLE. tvalid, tlast, tuser, tdata all 0. Delay line, len and counters 0. CRC register 0xFFFFFFFF.
- Outputs are registered. A beat on cycle n drives tvalid on cycle n+1 for exactly one clk.
- A payload byte leaves 5 beats after it entered.
- Beats may be spaced by any number of idle clk cycles (2.5/25 MHz modes). Outputs pulse once per beat, never held.
- A SFD beat produces no output.
- Reset during a frame: discard all state. The frame is neither output nor counted.
- A back-to-back preamble immediately after a dv=0 end beat must be detected. The end beat itself counts as IDLE.
- len saturates at MAX_FRAME_LEN+1.

## Configuration
- RX_MAC_STATS_EN defined: four 32-bit counters update on the cycle after each frame-end/abort decision. Counters saturate at 0xFFFFFFFF. stats_clear has priority over an increment in the same cycle. stat_good counts frames ending with tuser=0.
- Not defined: the counter logic is absent, all stat_* outputs are constant 0, and stats_clear is ignored.

## Test plan
- 7×0x55, 0xD5, 60-byte payload 0x00..0x3B, valid FCS, rdy=1 every cycle → 60 tvalid pulses with data 0x00..0x3B; tlast on 0x3B; tuser=0; stat_good=1.
- Same frame with the last FCS byte XOR 0x01 → 60 bytes, tlast with tuser=1, stat_fcs_err=1.
- PREAMBLE_MIN=7, only 5×0x55 then 0xD5 → no output. With PREAMBLE_MIN=4 the same stimulus → frame received.
- 1600-byte frame with MAX_FRAME_LEN=1518 → 1514 data pulses, the 1514th with tlast=1 and tuser=1; rest dropped; stat_len_err=1. Next valid frame received normally.
- trdy low for one beat mid-payload → that beat tlast=1, tuser=1; nothing more until dv falls; stat_ovf_err=1.
- rdy asserted every 10th cycle (25 MHz mode), 64-byte good frame → 60 pulses each exactly one clk wide, 10 cycles apart; reset_n pulsed mid-frame in a repeat run → outputs 0 and no counter change.

Source files
------------

// File: rtl/eth_rx_mac_pipe_if.sv
// Byte-wide AXI-Stream channel from the RX MAC to the RX asynchronous FIFO.
// The MAC drives data/valid/last/user; the FIFO returns trdy (space available).
interface eth_rx_mac_pipe_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;
    logic       trdy;

    modport master (output tdata, tvalid, tlast, tuser, input trdy);
    modport slave  (input tdata, tvalid, tlast, tuser, output trdy);
endinterface

// File: rtl/eth_rx_mac_pipe.sv
// RGMII-side receive MAC: preamble/SFD detect, 5-byte FCS-stripping delay line, frame checks.
// Define RX_MAC_STATS_EN to compile in the saturating good/fcs/len/ovf frame counters.
module eth_rx_mac_pipe #(
    parameter int PREAMBLE_MIN  = 7,
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               rgmii_mac_rx_data,
    input  logic                     rgmii_mac_rx_dv,
    input  logic                     rgmii_mac_rx_er,
    input  logic                     rgmii_mac_rx_rdy,
    eth_rx_mac_pipe_if.master        m_rx_axis,
    input  logic                     stats_clear,
    output logic [31:0]              stat_good,
    output logic [31:0]              stat_fcs_err,
    output logic [31:0]              stat_len_err,
    output logic [31:0]              stat_ovf_err
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

    localparam logic [2:0]  PRE_MIN  = 3'(PREAMBLE_MIN);
    localparam logic [14:0] MIN_LEN  = 15'(MIN_FRAME_LEN);
    localparam logic [14:0] MAX_LEN  = 15'(MAX_FRAME_LEN);
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE  = 32'hDEBB_20E3;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] r;
        r = crc;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ data[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [7:0]  dly_q [5];
    logic [7:0]  dly_d [5];
    logic [4:0]  vld_q, vld_d;
    logic [14:0] len_q, len_d;
    logic [31:0] crc_q, crc_d;
    logic        err_phy_q, err_phy_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic        ev_good, ev_fcs, ev_len, ev_ovf;
    logic        beat;

    assign beat = rgmii_mac_rx_rdy;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        dly_d     = dly_q;
        vld_d     = vld_q;
        len_d     = len_q;
        crc_d     = crc_q;
        err_phy_d = err_phy_q;
        tdata_d   = 8'h00;
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;
        tuser_d   = 1'b0;
        ev_good   = 1'b0;
        ev_fcs    = 1'b0;
        ev_len    = 1'b0;
        ev_ovf    = 1'b0;

        if (beat) begin
            unique case (state_q)
                IDLE: begin
                    if (rgmii_mac_rx_dv && rgmii_mac_rx_data == 8'h55) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = 3'd1;
                    end
                end
                PREAMBLE: begin
                    if (rgmii_mac_rx_dv && rgmii_mac_rx_data == 8'h55) begin
                        pre_cnt_d = (pre_cnt_q == 3'd7) ? pre_cnt_q : pre_cnt_q + 3'd1;
                    end else if (rgmii_mac_rx_dv && rgmii_mac_rx_data == 8'hD5 &&
                                 pre_cnt_q >= PRE_MIN && m_rx_axis.trdy) begin
                        state_d   = PAYLOAD;
                        vld_d     = '0;
                        len_d     = '0;
                        crc_d     = CRC_INIT;
                        err_phy_d = 1'b0;
                        for (int i = 0; i < 5; i++) dly_d[i] = 8'h00;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PAYLOAD: begin
                    tdata_d = vld_q[4] ? dly_q[4] : 8'h00;
                    if (!m_rx_axis.trdy) begin
                        // FIFO full: close the frame on this beat whether or not a byte was due.
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                        tuser_d  = 1'b1;
                        ev_ovf   = 1'b1;
                        state_d  = DROP;
                    end else if (rgmii_mac_rx_dv) begin
                        tvalid_d  = vld_q[4];
                        dly_d[0]  = rgmii_mac_rx_data;
                        for (int i = 1; i < 5; i++) dly_d[i] = dly_q[i-1];
                        vld_d     = {vld_q[3:0], 1'b1};
                        crc_d     = crc32_byte(crc_q, rgmii_mac_rx_data);
                        len_d     = (len_q > MAX_LEN) ? len_q : len_q + 15'd1;
                        err_phy_d = err_phy_q | rgmii_mac_rx_er;
                        if (len_q == MAX_LEN) begin
                            tvalid_d = 1'b1;
                            tlast_d  = 1'b1;
                            tuser_d  = 1'b1;
                            ev_len   = 1'b1;
                            state_d  = DROP;
                        end
                    end else begin
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                        state_d  = IDLE;
                        if (!vld_q[4] || len_q < MIN_LEN) begin
                            tuser_d = 1'b1;
                            ev_len  = 1'b1;
                        end else if (crc_q != RESIDUE || err_phy_q) begin
                            tuser_d = 1'b1;
                            ev_fcs  = 1'b1;
                        end else begin
                            ev_good = 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (!rgmii_mac_rx_dv) state_d = IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pre_cnt_q <= '0;
            // NOTE: the delay line is only five bytes of flops, so it is cleared like any other register.
            for (int i = 0; i < 5; i++) dly_q[i] <= 8'h00;
            vld_q     <= '0;
            len_q     <= '0;
            crc_q     <= CRC_INIT;
            err_phy_q <= 1'b0;
            tdata_q   <= 8'h00;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            dly_q     <= dly_d;
            vld_q     <= vld_d;
            len_q     <= len_d;
            crc_q     <= crc_d;
            err_phy_q <= err_phy_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
        end
    end

    assign m_rx_axis.tdata  = tdata_q;
    assign m_rx_axis.tvalid = tvalid_q;
    assign m_rx_axis.tlast  = tlast_q;
    assign m_rx_axis.tuser  = tuser_q;

`ifdef RX_MAC_STATS_EN
    logic [31:0] good_q, fcs_q, len_err_q, ovf_q;

    always_ff @(posedge clk) begin
        if (!reset_n || stats_clear) begin
            good_q    <= '0;
            fcs_q     <= '0;
            len_err_q <= '0;
            ovf_q     <= '0;
        end else begin
            if (ev_good && good_q    != '1) good_q    <= good_q    + 32'd1;
            if (ev_fcs  && fcs_q     != '1) fcs_q     <= fcs_q     + 32'd1;
            if (ev_len  && len_err_q != '1) len_err_q <= len_err_q + 32'd1;
            if (ev_ovf  && ovf_q     != '1) ovf_q     <= ovf_q     + 32'd1;
        end
    end

    assign stat_good    = good_q;
    assign stat_fcs_err = fcs_q;
    assign stat_len_err = len_err_q;
    assign stat_ovf_err = ovf_q;
`else
    logic stats_unused;
    assign stats_unused = ^{stats_clear, ev_good, ev_fcs, ev_len, ev_ovf};

    assign stat_good    = '0;
    assign stat_fcs_err = '0;
    assign stat_len_err = '0;
    assign stat_ovf_err = '0;
`endif

endmodule

// File: tb/tb_eth_rx_mac_pipe.sv
// Directed bench for eth_rx_mac_pipe: a frame-scenario table plus hand-written corner sequences.
// dut_a uses PREAMBLE_MIN=7, dut_b PREAMBLE_MIN=4; both see identical stimulus.
`timescale 1ns/1ps
module tb_eth_rx_mac_pipe;

`ifdef RX_MAC_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_dv, rx_er, rx_rdy, trdy, stats_clear;
    logic [31:0] a_good, a_fcs, a_len, a_ovf;
    logic [31:0] b_good, b_fcs, b_len, b_ovf;

    always #5 clk = ~clk;

    eth_rx_mac_pipe_if axis_a ();
    eth_rx_mac_pipe_if axis_b ();
    assign axis_a.trdy = trdy;
    assign axis_b.trdy = trdy;

    eth_rx_mac_pipe dut_a (
        .clk(clk), .reset_n(reset_n),
        .rgmii_mac_rx_data(rx_data), .rgmii_mac_rx_dv(rx_dv),
        .rgmii_mac_rx_er(rx_er), .rgmii_mac_rx_rdy(rx_rdy),
        .m_rx_axis(axis_a), .stats_clear(stats_clear),
        .stat_good(a_good), .stat_fcs_err(a_fcs), .stat_len_err(a_len), .stat_ovf_err(a_ovf)
    );

    eth_rx_mac_pipe #(.PREAMBLE_MIN(4)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .rgmii_mac_rx_data(rx_data), .rgmii_mac_rx_dv(rx_dv),
        .rgmii_mac_rx_er(rx_er), .rgmii_mac_rx_rdy(rx_rdy),
        .m_rx_axis(axis_b), .stats_clear(stats_clear),
        .stat_good(b_good), .stat_fcs_err(b_fcs), .stat_len_err(b_len), .stat_ovf_err(b_ovf)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         cyc;
    } pulse_t;

    typedef struct {
        string name;
        int    pre;
        int    plen;
        bit    bad_fcs;
        int    er_idx;
        int    ovf_idx;
        int    sp;
        int    a_pulses;
        bit    a_user;
        int    b_pulses;
        bit    b_user;
        int    d_good;
        int    d_fcs;
        int    d_len;
        int    d_ovf;
    } scen_t;

    pulse_t     mon_a [$];
    int         b_pulses = 0;
    logic       b_last_user = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] frm [0:2047];
    int         frm_len;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (axis_a.tvalid === 1'b1)
            mon_a.push_back('{data: axis_a.tdata, last: axis_a.tlast, user: axis_a.tuser, cyc: cyc});
        if (axis_b.tvalid === 1'b1) begin
            b_pulses <= b_pulses + 1;
            if (axis_b.tlast === 1'b1) b_last_user <= axis_b.tuser;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Payload bytes are i mod 256; the FCS is the complemented reflected CRC-32, sent LSB first.
    task automatic build_frame(input int plen, input bit bad_fcs);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < plen; i++) begin
            frm[i] = 8'(i);
            c = c ^ {24'h0, frm[i]};
            repeat (8) c = (c >> 1) ^ (32'hEDB8_8320 & {32{c[0]}});
        end
        c = ~c;
        for (int j = 0; j < 4; j++) frm[plen + j] = c[8*j +: 8];
        if (bad_fcs) frm[plen + 3] = frm[plen + 3] ^ 8'h01;
        frm_len = plen + 4;
    endtask

    task automatic beat(input logic [7:0] d, input logic v, input logic e, input logic t, input int sp);
        rx_data = d;
        rx_dv   = v;
        rx_er   = e;
        trdy    = t;
        rx_rdy  = 1'b1;
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        rx_er  = 1'b0;
        trdy   = 1'b1;
        for (int i = 1; i < sp; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int pre, input int plen, input bit bad, input int er_idx,
                              input int ovf_idx, input int sp, input int idle_after);
        build_frame(plen, bad);
        for (int i = 0; i < pre; i++) beat(8'h55, 1'b1, 1'b0, 1'b1, sp);
        beat(8'hD5, 1'b1, 1'b0, 1'b1, sp);
        for (int i = 0; i < frm_len; i++) beat(frm[i], 1'b1, i == er_idx, i != ovf_idx, sp);
        beat(8'h00, 1'b0, 1'b0, 1'b1, sp);
        for (int i = 0; i < idle_after; i++) beat(8'h00, 1'b0, 1'b0, 1'b1, sp);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic int count_last(input int start);
        int n = 0;
        for (int i = start; i < mon_a.size(); i++) if (mon_a[i].last === 1'b1) n++;
        return n;
    endfunction

    scen_t tbl [9];

    initial begin
        int start, b_start, n, mism, gaps, nlast;
        logic [31:0] c0 [4];

        tbl[0] = '{"good60",     7, 60,   1'b0, -1, -1, 1,  60,   1'b0, 60,   1'b0, 1, 0, 0, 0};
        tbl[1] = '{"bad_fcs",    7, 60,   1'b1, -1, -1, 1,  60,   1'b1, 60,   1'b1, 0, 1, 0, 0};
        tbl[2] = '{"pre5",       5, 60,   1'b0, -1, -1, 1,  0,    1'b0, 60,   1'b0, 0, 0, 0, 0};
        tbl[3] = '{"oversize",   7, 1596, 1'b0, -1, -1, 1,  1514, 1'b1, 1514, 1'b1, 0, 0, 1, 0};
        tbl[4] = '{"good_after", 7, 60,   1'b0, -1, -1, 1,  60,   1'b0, 60,   1'b0, 1, 0, 0, 0};
        tbl[5] = '{"overflow",   7, 60,   1'b0, -1, 30, 1,  26,   1'b1, 26,   1'b1, 0, 0, 0, 1};
        tbl[6] = '{"phy_er",     7, 60,   1'b0, 10, -1, 1,  60,   1'b1, 60,   1'b1, 0, 1, 0, 0};
        tbl[7] = '{"short40",    7, 40,   1'b0, -1, -1, 1,  40,   1'b1, 40,   1'b1, 0, 0, 1, 0};
        tbl[8] = '{"slow25",     7, 60,   1'b0, -1, -1, 10, 60,   1'b0, 60,   1'b0, 1, 0, 0, 0};

        reset_n = 1'b0; rx_data = 8'h00; rx_dv = 1'b0; rx_er = 1'b0;
        rx_rdy = 1'b0; trdy = 1'b1; stats_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.tvalid", axis_a.tvalid, 0);
        check("reset.tlast",  axis_a.tlast,  0);
        check("reset.tuser",  axis_a.tuser,  0);
        check("reset.tdata",  axis_a.tdata,  0);
        check("reset.stat_good", a_good, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int r = 0; r < 9; r++) begin
            start   = mon_a.size();
            b_start = b_pulses;
            c0 = '{a_good, a_fcs, a_len, a_ovf};
            send_frame(tbl[r].pre, tbl[r].plen, tbl[r].bad_fcs, tbl[r].er_idx,
                       tbl[r].ovf_idx, tbl[r].sp, 2);
            n = mon_a.size() - start;
            check({tbl[r].name, ".pulses"}, n, tbl[r].a_pulses);
            mism = 0; gaps = 0;
            for (int i = 0; i < n; i++) begin
                if (mon_a[start + i].data !== frm[i]) mism++;
                if (i > 0 && mon_a[start + i].cyc - mon_a[start + i - 1].cyc != tbl[r].sp) gaps++;
            end
            check({tbl[r].name, ".data_mismatches"}, mism, 0);
            check({tbl[r].name, ".pulse_spacing_errors"}, gaps, 0);
            nlast = count_last(start);
            check({tbl[r].name, ".tlast_count"}, nlast, (tbl[r].a_pulses > 0) ? 1 : 0);
            if (n > 0) begin
                check({tbl[r].name, ".tlast_on_final"}, mon_a[start + n - 1].last, 1);
                check({tbl[r].name, ".tuser"}, mon_a[start + n - 1].user, tbl[r].a_user);
            end
            check({tbl[r].name, ".b_pulses"}, b_pulses - b_start, tbl[r].b_pulses);
            check({tbl[r].name, ".b_tuser"}, b_last_user, tbl[r].b_user);
            check({tbl[r].name, ".d_good"}, a_good - c0[0], STATS * tbl[r].d_good);
            check({tbl[r].name, ".d_fcs"},  a_fcs  - c0[1], STATS * tbl[r].d_fcs);
            check({tbl[r].name, ".d_len"},  a_len  - c0[2], STATS * tbl[r].d_len);
            check({tbl[r].name, ".d_ovf"},  a_ovf  - c0[3], STATS * tbl[r].d_ovf);
        end

        // Runt: only the 4 FCS bytes arrive, so no real byte can carry tlast.
        start = mon_a.size();
        c0[2] = a_len;
        send_frame(7, 0, 1'b0, -1, -1, 1, 2);
        check("runt.pulses", mon_a.size() - start, 1);
        if (mon_a.size() > start) begin
            check("runt.tdata", mon_a[start].data, 0);
            check("runt.tlast", mon_a[start].last, 1);
            check("runt.tuser", mon_a[start].user, 1);
        end
        check("runt.d_len", a_len - c0[2], STATS);

        // Back-to-back: the next preamble starts on the beat right after the dv=0 end beat.
        start = mon_a.size();
        c0[0] = a_good;
        send_frame(7, 60, 1'b0, -1, -1, 1, 0);
        send_frame(7, 60, 1'b0, -1, -1, 1, 2);
        check("b2b.pulses", mon_a.size() - start, 120);
        check("b2b.tlast_count", count_last(start), 2);
        check("b2b.d_good", a_good - c0[0], 2 * STATS);

        // Reset pulsed mid-frame in 25 MHz mode: the partial frame is neither output nor counted.
        build_frame(60, 1'b0);
        for (int i = 0; i < 7; i++) beat(8'h55, 1'b1, 1'b0, 1'b1, 10);
        beat(8'hD5, 1'b1, 1'b0, 1'b1, 10);
        for (int i = 0; i < 20; i++) beat(frm[i], 1'b1, 1'b0, 1'b1, 10);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midrst.tvalid", axis_a.tvalid, 0);
        check("midrst.tlast",  axis_a.tlast,  0);
        check("midrst.tuser",  axis_a.tuser,  0);
        check("midrst.tdata",  axis_a.tdata,  0);
        start = mon_a.size();
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 20; i < frm_len; i++) beat(frm[i], 1'b1, 1'b0, 1'b1, 10);
        beat(8'h00, 1'b0, 1'b0, 1'b1, 10);
        repeat (3) @(posedge clk);
        #1;
        check("midrst.pulses_after", mon_a.size() - start, 0);
        check("midrst.counters", a_good + a_fcs + a_len + a_ovf, 0);

        start = mon_a.size();
        send_frame(7, 60, 1'b0, -1, -1, 1, 2);
        check("recover.pulses", mon_a.size() - start, 60);
        check("recover.stat_good", a_good, STATS);

        stats_clear = 1'b1;
        @(posedge clk); #1;
        stats_clear = 1'b0;
        check("clear.stat_good", a_good, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
